branch_predictor_bht: RTL and testbench

BRANCH_PREDICTOR_BHT -- requirements
Module: branch_predictor_bht

---
 rtl/bp_pkg.sv | 20 ++
 rtl/bp_sat_counter.sv | 38 +++
 rtl/branch_predictor_bht.sv | 122 ++++++++++++
 tb/tb_branch_predictor_bht.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch history table: FSM state encoding and
// counter constants computed from the counter width.
package bp_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } bp_state_e;

    // Weakly-not-taken value: the largest count whose MSB is still 0.
    function automatic logic [3:0] ctr_weak_nt(input int ctr_bits);
        return 4'((32'd1 << (ctr_bits - 1)) - 32'd1);
    endfunction

    // Saturation ceiling of a ctr_bits-wide counter.
    function automatic logic [3:0] ctr_max(input int ctr_bits);
        return 4'((32'd1 << ctr_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down counter used as one branch history table entry;
// reset and load both return it to weakly-not-taken.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int CTR_BITS = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic                en,
    input  logic                up,
    output logic [CTR_BITS-1:0] count
);

    localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'(ctr_weak_nt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] MAX_VAL  = CTR_BITS'(ctr_max(CTR_BITS));

    // Counter state: init load has priority over a training step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= INIT_VAL;
        end else if (load) begin
            count <= INIT_VAL;
        end else if (en) begin
            if (up) begin
                if (count != MAX_VAL) begin
                    count <= count + CTR_BITS'(1);
                end
            end else begin
                if (count != {CTR_BITS{1'b0}}) begin
                    count <= count - CTR_BITS'(1);
                end
            end
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Bimodal branch history table with a one-entry-per-cycle clear sweep.
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int MISS_BITS  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           pred_pc,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    input  logic                  upd_pred,
    input  logic                  clear,
    output logic                  busy,
    output logic [MISS_BITS-1:0]  miss_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(ENTRIES - 1);
    localparam logic [MISS_BITS-1:0]  MISS_MAX = {MISS_BITS{1'b1}};

    bp_state_e             state;
    logic [INDEX_BITS-1:0] sweep_idx;
    logic [CTR_BITS-1:0]   ctr [ENTRIES];
    logic                  upd_accept;
    logic                  unused_pc_bits;

    // An update counts only in IDLE and only when no clear competes with it.
    assign upd_accept     = (state == ST_IDLE) && upd_valid && !clear;
    assign unused_pc_bits = ^pred_pc[31:INDEX_BITS];

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        bp_sat_counter #(
            .CTR_BITS (CTR_BITS)
        ) u_ctr (
            .clock (clock),
            .reset (reset),
            .load  ((state == ST_CLEAR) && (sweep_idx == INDEX_BITS'(i))),
            .en    (upd_accept && (upd_index == INDEX_BITS'(i))),
            .up    (upd_taken),
            .count (ctr[i])
        );
    end

`ifdef BP_GSHARE_EN
    logic [INDEX_BITS-1:0] history;

    // Global outcome history, cleared at sweep start so the fresh table is indexed from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            history <= {INDEX_BITS{1'b0}};
        end else if ((state == ST_IDLE) && clear) begin
            history <= {INDEX_BITS{1'b0}};
        end else if (upd_accept) begin
            history <= {history[INDEX_BITS-2:0], upd_taken};
        end
    end

    assign pred_index = pred_pc[INDEX_BITS-1:0] ^ history;
`else
    assign pred_index = pred_pc[INDEX_BITS-1:0];
`endif

    // Prediction is the entry MSB, suppressed while the table is being rewritten.
    always_comb begin
        pred_taken = 1'b0;
        if (busy) begin
            pred_taken = 1'b0;
        end else begin
            pred_taken = ctr[pred_index][CTR_BITS-1];
        end
    end

    // Clear sweep FSM: busy mirrors the CLEAR state as a registered output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            sweep_idx <= {INDEX_BITS{1'b0}};
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        state     <= ST_CLEAR;
                        sweep_idx <= {INDEX_BITS{1'b0}};
                        busy      <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (sweep_idx == LAST_IDX) begin
                        state     <= ST_IDLE;
                        sweep_idx <= {INDEX_BITS{1'b0}};
                        busy      <= 1'b0;
                    end else begin
                        sweep_idx <= sweep_idx + INDEX_BITS'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    sweep_idx <= {INDEX_BITS{1'b0}};
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Mispredict counter survives clear and sticks at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miss_count <= {MISS_BITS{1'b0}};
        end else if (upd_accept && (upd_pred != upd_taken) && (miss_count != MISS_MAX)) begin
            miss_count <= miss_count + MISS_BITS'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: directed vector table, clear/reset
// sequences, and randomized traffic against a behavioural table model.
module tb_branch_predictor_bht;

    localparam int IB = 6;
    localparam int CB = 2;
    localparam int MB = 8;
    localparam int NENT = 1 << IB;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   pred_pc;
    logic          pred_taken;
    logic [IB-1:0] pred_index;
    logic          upd_valid;
    logic [IB-1:0] upd_index;
    logic          upd_taken;
    logic          upd_pred;
    logic          clear;
    logic          busy;
    logic [MB-1:0] miss_count;

    int total = 0;
    int bad   = 0;

    // Behavioural model: counter values, history, mispredicts, sweep cycles remaining.
    int m_tbl [NENT];
    int m_hist;
    int m_miss;
    int m_busy;

    branch_predictor_bht #(
        .INDEX_BITS (IB),
        .CTR_BITS   (CB),
        .MISS_BITS  (MB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pred_pc    (pred_pc),
        .pred_taken (pred_taken),
        .pred_index (pred_index),
        .upd_valid  (upd_valid),
        .upd_index  (upd_index),
        .upd_taken  (upd_taken),
        .upd_pred   (upd_pred),
        .clear      (clear),
        .busy       (busy),
        .miss_count (miss_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        foreach (m_tbl[i]) m_tbl[i] = 1;
        m_hist = 0;
        m_miss = 0;
        m_busy = 0;
    endfunction

    // One rising edge of the model, using the inputs present at that edge.
    function automatic void model_edge();
        if (m_busy > 0) begin
            m_busy--;
        end else if (clear) begin
            foreach (m_tbl[i]) m_tbl[i] = 1;
            m_busy = NENT;
            m_hist = 0;
        end else if (upd_valid) begin
            if (upd_taken) m_tbl[upd_index] = (m_tbl[upd_index] < 3) ? m_tbl[upd_index] + 1 : 3;
            else           m_tbl[upd_index] = (m_tbl[upd_index] > 0) ? m_tbl[upd_index] - 1 : 0;
            if ((upd_pred != upd_taken) && (m_miss < 255)) m_miss++;
`ifdef BP_GSHARE_EN
            m_hist = ((m_hist * 2) + int'(upd_taken)) % NENT;
`endif
        end
    endfunction

    task automatic check_model(input string tag);
        int e;
        e = (int'(pred_pc[IB-1:0]) ^ m_hist) % NENT;
        check({tag, "_idx"},  32'(pred_index), 32'(e));
        check({tag, "_pt"},   32'(pred_taken), 32'((m_busy == 0) && (m_tbl[e] >= 2)));
        check({tag, "_busy"}, 32'(busy),       32'(m_busy > 0));
        check({tag, "_miss"}, 32'(miss_count), 32'(m_miss));
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic          clr;
        logic          uv;
        logic [IB-1:0] ui;
        logic          ut;
        logic          up;
        logic [31:0]   pc;
        logic          e_pt;
        logic [IB-1:0] e_idx;
        logic          e_busy;
        logic [MB-1:0] e_miss;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int saved_miss;

        vecs[0]  = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'hFFFF_FFC5, 1'b0, 6'd5, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b1, 6'd5, 1'b1, 1'b0, 32'd5, 1'b0, 6'd5, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 6'd5, 1'b1, 1'b0, 32'd5, 1'b1, 6'd5, 1'b0, 8'd1};
        vecs[3]  = '{1'b0, 1'b1, 6'd5, 1'b1, 1'b1, 32'd5, 1'b1, 6'd5, 1'b0, 8'd2};
        vecs[4]  = '{1'b0, 1'b1, 6'd5, 1'b0, 1'b1, 32'd5, 1'b1, 6'd5, 1'b0, 8'd2};
        vecs[5]  = '{1'b0, 1'b1, 6'd5, 1'b0, 1'b1, 32'd5, 1'b1, 6'd5, 1'b0, 8'd3};
        vecs[6]  = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'd5, 1'b0, 6'd5, 1'b0, 8'd4};
        vecs[7]  = '{1'b0, 1'b1, 6'd3, 1'b1, 1'b0, 32'd3, 1'b0, 6'd3, 1'b0, 8'd4};
        vecs[8]  = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'd3, 1'b1, 6'd3, 1'b0, 8'd5};
        vecs[9]  = '{1'b0, 1'b1, 6'd3, 1'b0, 1'b1, 32'd3, 1'b1, 6'd3, 1'b0, 8'd5};
        vecs[10] = '{1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 32'd3, 1'b0, 6'd3, 1'b0, 8'd6};
        vecs[11] = '{1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 32'd0, 1'b0, 6'd0, 1'b0, 8'd6};
        vecs[12] = '{1'b0, 1'b1, 6'd0, 1'b1, 1'b0, 32'd0, 1'b0, 6'd0, 1'b0, 8'd6};
        vecs[13] = '{1'b0, 1'b1, 6'd0, 1'b1, 1'b1, 32'd0, 1'b0, 6'd0, 1'b0, 8'd7};
        vecs[14] = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 1'b1, 6'd0, 1'b0, 8'd7};

        reset = 1'b1; clear = 1'b0; upd_valid = 1'b0; upd_index = '0;
        upd_taken = 1'b0; upd_pred = 1'b0; pred_pc = 32'd0;
        model_reset();
        #12;
        reset = 1'b0;

`ifdef BP_GSHARE_EN
        // History shift: T, N, T gives 3'b101, so pc 0 indexes entry 5.
        upd_valid = 1'b1; upd_index = 6'd1; upd_pred = 1'b1;
        upd_taken = 1'b1; tick();
        upd_taken = 1'b0; tick();
        upd_taken = 1'b1; tick();
        upd_valid = 1'b0; pred_pc = 32'd0; #1;
        check("gshare_idx", 32'(pred_index), 32'd5);
        check_model("gshare");
`else
        for (int i = 0; i < 15; i++) begin
            clear = vecs[i].clr; upd_valid = vecs[i].uv; upd_index = vecs[i].ui;
            upd_taken = vecs[i].ut; upd_pred = vecs[i].up; pred_pc = vecs[i].pc;
            #1;
            check($sformatf("vec%0d_pt", i),   32'(pred_taken), 32'(vecs[i].e_pt));
            check($sformatf("vec%0d_idx", i),  32'(pred_index), 32'(vecs[i].e_idx));
            check($sformatf("vec%0d_busy", i), 32'(busy),       32'(vecs[i].e_busy));
            check($sformatf("vec%0d_miss", i), 32'(miss_count), 32'(vecs[i].e_miss));
            tick();
        end
`endif

        // Clear collides with an update: clear wins, then a 64-cycle sweep.
        saved_miss = m_miss;
        clear = 1'b1; upd_valid = 1'b1; upd_index = 6'd0; upd_taken = 1'b1; upd_pred = 1'b0;
        pred_pc = 32'd0;
        #1;
        check("pre_clear_busy", 32'(busy), 32'd0);
        tick();
        clear = 1'b0;
        check("busy_start", 32'(busy), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            clear = (n == 30);
            upd_index = 6'($urandom_range(0, NENT - 1));
            pred_pc = {26'($urandom), upd_index};
            #1;
            check("sweep_pt", 32'(pred_taken), 32'd0);
            check_model("sweep");
            tick();
            n++;
        end
        check("sweep_len", 32'(n), 32'd64);
        check("miss_kept", 32'(miss_count), 32'(saved_miss));
        clear = 1'b0; upd_valid = 1'b0;
        for (int i = 0; i < NENT; i++) begin
            pred_pc = 32'(i); #1;
            check("post_clear_pt", 32'(pred_taken), 32'd0);
        end
        upd_valid = 1'b1; upd_index = 6'd0; upd_taken = 1'b1; upd_pred = 1'b1;
        tick();
        upd_valid = 1'b0; pred_pc = 32'd0; #1;
        check_model("post_clear_upd");

        // Reset in the middle of a sweep aborts it and leaves a fresh table.
        clear = 1'b1; tick(); clear = 1'b0;
        repeat (10) tick();
        #2 reset = 1'b1; model_reset();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_miss", 32'(miss_count), 32'd0);
        @(negedge clock); reset = 1'b0;
        for (int i = 0; i < NENT; i++) begin
            pred_pc = 32'(i); #1;
            check("post_rst_pt", 32'(pred_taken), 32'd0);
        end
        tick();
        check_model("post_rst");

        // Random traffic on a few indices so counters hit both rails.
        for (int c = 0; c < 3000; c++) begin
            clear     = ($urandom_range(0, 299) == 0);
            upd_valid = 1'($urandom);
            upd_index = 6'($urandom_range(0, 7));
            upd_taken = 1'($urandom);
            upd_pred  = 1'($urandom);
            pred_pc   = {26'($urandom), 6'($urandom_range(0, 7))};
            #1;
            check_model("rand");
            tick();
        end

        // Mispredict counter saturation after 2**MB+3 misses.
        clear = 1'b0; upd_valid = 1'b0;
        #2 reset = 1'b1; model_reset();
        @(negedge clock); reset = 1'b0;
        upd_valid = 1'b1; upd_index = 6'd7;
        for (int k = 0; k < (1 << MB) + 3; k++) begin
            upd_taken = 1'($urandom);
            upd_pred  = ~upd_taken;
            tick();
            if (k == 254) check("miss_255", 32'(miss_count), 32'd255);
        end
        upd_valid = 1'b0; #1;
        check("miss_sat", 32'(miss_count), 32'hFF);
        check_model("miss_sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
